// File: rtl/dot_product_pkg.sv
// Shared types and arithmetic helpers for the dot-product compute stage.
// Define DOT_PRODUCT_PE_SATURATE_EN for saturating adds; otherwise adds wrap.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int NUM_PIPELINE_STAGES = 4;

  // Operands must already fit in w bits; the result is valid in its low w bits.
  function automatic logic [31:0] add_w(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
`ifdef DOT_PRODUCT_PE_SATURATE_EN
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (s > lim) s = lim;
    return s[31:0];
`else
    return (a + b) & ((32'd1 << w) - 32'd1);
`endif
  endfunction

endpackage

// File: rtl/dot_product_pe_if.sv
// Beat bus between the SRAM read ports, the compute stage and the
// output SRAM write port.
interface dot_product_pe_if #(
  parameter int Para_Deg       = 1,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16
);

  logic                                In_valid;
  logic                                Load_old_output;
  logic [Para_Deg*Data_Width_In-1:0]   A_data;
  logic [Para_Deg*Data_Width_In-1:0]   B_data;
  logic [Para_Deg*Data_Width_Out-1:0]  Old_data;
  logic                                Out_valid;
  logic [Para_Deg*Data_Width_Out-1:0]  Out_data;

  modport master (
    output In_valid,
    output Load_old_output,
    output A_data,
    output B_data,
    output Old_data,
    input  Out_valid,
    input  Out_data
  );

  modport slave (
    input  In_valid,
    input  Load_old_output,
    input  A_data,
    input  B_data,
    input  Old_data,
    output Out_valid,
    output Out_data
  );

endinterface

// File: rtl/dot_product_lane.sv
// One lane of the S1-S4 datapath: register operands, multiply, add old,
// register result. Valids live in the parent.
module dot_product_lane
  import dot_product_pkg::*;
#(
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic                      i_ld4,
  input  logic [Data_Width_In-1:0]  i_a,
  input  logic [Data_Width_In-1:0]  i_b,
  input  logic [Data_Width_Out-1:0] i_old,
  output logic [Data_Width_Out-1:0] o_prod,
  output logic [Data_Width_Out-1:0] o_out
);

  logic [Data_Width_In-1:0]  r_a;
  logic [Data_Width_In-1:0]  r_b;
  logic [Data_Width_Out-1:0] r_old1;
  logic [Data_Width_Out-1:0] r_prod;
  logic [Data_Width_Out-1:0] r_old2;
  logic [Data_Width_Out-1:0] r_sum;
  logic [Data_Width_Out-1:0] r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_old1 <= '0;
      r_prod <= '0;
      r_old2 <= '0;
      r_sum  <= '0;
    end else if (i_en) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_old1 <= i_old;
      r_prod <= Data_Width_Out'(r_a)
              * Data_Width_Out'(r_b);
      r_old2 <= r_old1;
      r_sum  <= Data_Width_Out'(add_w(
                  32'(r_prod),
                  32'(r_old2),
                  Data_Width_Out));
    end
  end

  // Output word only moves when a valid beat lands, so it holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else if (i_ld4) r_out <= r_sum;
  end

  assign o_prod = r_prod;
  assign o_out  = r_out;

endmodule

// File: rtl/dot_product_pe.sv
// Dot-product compute stage: Para_Deg lanes, beat sum, frame accumulator,
// step counter and frame FSM. Option: DOT_PRODUCT_PE_SATURATE_EN.
module dot_product_pe
  import dot_product_pkg::*;
#(
  parameter int Para_Deg             = 1,
  parameter int Data_Width_In        = 8,
  parameter int Data_Width_Out       = 16,
  parameter int Nums_Data_in_bits    = 4,
  parameter int Nums_Data            = 1 << Nums_Data_in_bits,
  parameter int Nums_Pipeline_Stages = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        Start,
  input  logic                        Stall,
  dot_product_pe_if.slave             bus,
  output logic [Data_Width_Out-1:0]   Dot_result,
  output logic [Nums_Data_in_bits:0]  Step_count,
  output logic                        Busy,
  output logic                        Done
);

  localparam int DWI = Data_Width_In;
  localparam int DWO = Data_Width_Out;
  localparam int SW  = Nums_Data_in_bits + 1;

  if (Nums_Pipeline_Stages != NUM_PIPELINE_STAGES) begin : g_bad_stages
    $error("dot_product_pe: Nums_Pipeline_Stages must be 4");
  end
  if ((Nums_Data % Para_Deg) != 0) begin : g_bad_frame
    $error("dot_product_pe: Nums_Data must be a multiple of Para_Deg");
  end

  state_t r_state;
  state_t w_next;

  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  logic             r_v4;
  logic [DWO-1:0]   r_beat_sum;
  logic [DWO-1:0]   r_dot;
  logic [SW-1:0]    r_step;

  logic                  w_en;
  logic                  w_ld4;
  logic                  w_accept;
  logic                  w_last;
  logic [SW-1:0]         w_step_nxt;
  logic [DWO-1:0]        w_lane_sum;
  logic [Para_Deg*DWO-1:0] w_old;
  logic [Para_Deg*DWO-1:0] w_out;
  logic [DWO-1:0]        w_prod [Para_Deg];

  assign w_en       = ~Stall;
  assign w_ld4      = ~Stall & ~Start & r_v3;
  assign w_accept   = bus.In_valid & ~Stall & ~Start
                    & (r_state == RUN);
  assign w_step_nxt = r_step + SW'(Para_Deg);
  assign w_last     = (w_step_nxt == SW'(Nums_Data));
  assign w_old      = bus.Load_old_output
                    ? bus.Old_data : '0;

  for (genvar l = 0; l < Para_Deg; l++) begin : g_lane
    dot_product_lane #(
      .Data_Width_In  (DWI),
      .Data_Width_Out (DWO)
    ) u_lane (
      .clk    (clk),
      .rst_n  (reset_n),
      .i_en   (w_en),
      .i_ld4  (w_ld4),
      .i_a    (bus.A_data[l*DWI +: DWI]),
      .i_b    (bus.B_data[l*DWI +: DWI]),
      .i_old  (w_old[l*DWO +: DWO]),
      .o_prod (w_prod[l]),
      .o_out  (w_out[l*DWO +: DWO])
    );
  end

  always_comb begin
    w_lane_sum = '0;
    for (int l = 0; l < Para_Deg; l++) begin
      w_lane_sum = DWO'(add_w(32'(w_lane_sum),
                              32'(w_prod[l]), DWO));
    end
  end

  // Start flushes valids even while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else if (Start) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else if (!Stall) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_sum <= '0;
      r_dot      <= '0;
      r_step     <= '0;
    end else if (Start) begin
      r_dot      <= '0;
      r_step     <= '0;
    end else if (!Stall) begin
      r_beat_sum <= w_lane_sum;
      if (r_v3) begin
        r_dot <= DWO'(add_w(32'(r_dot),
                            32'(r_beat_sum), DWO));
      end
      if (w_accept) r_step <= w_step_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // In DRAIN the youngest beat is the frame's last one.
  always_comb begin
    w_next = r_state;
    if (Start) begin
      w_next = RUN;
    end else if (!Stall) begin
      unique case (r_state)
        IDLE:  w_next = IDLE;
        RUN:   if (w_accept && w_last) w_next = DRAIN;
        DRAIN: if (r_v3 && !r_v2 && !r_v1) w_next = DONE;
        DONE:  w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  assign bus.Out_valid = r_v4;
  assign bus.Out_data  = w_out;
  assign Dot_result    = r_dot;
  assign Step_count    = r_step;
  assign Busy          = (r_state != IDLE);
  assign Done          = (r_state == DONE) & ~Stall;

endmodule
